operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side operand fetch stage: accepts an instruction from the IF/ID side, drives the register file read selects, applies same-cycle write-back bypass, and holds a register scoreboard that stalls on pending writes. It registers the instruction, its operands and its destination into an output slot consumed by the execute stage over a valid/ready handshake. It sits between instruction fetch and execute, directly upstream of the register file's read ports.

## Interface
- Parameters:
- WB_BYPASS, 1, when 1, a write-back to a source register in the same cycle supplies the operand; when 0, the RF read data is always used and such a source stalls one cycle.
- Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_instr  in  word_t  MIPS instruction
- in_pc  in  word_t  PC of in_instr
- flush  in  1  kill the output slot
- rf_rsel1, rf_rsel2  out  regbits_t  register file read selects (rs, rt)
- rf_rdat1, rf_rdat2  in  word_t  register file read data (combinational)
- wb_wen, wb_wsel, wb_wdat  in  1 / regbits_t / word_t  snoop of the register file write port
- out_valid  out  1  output slot full
- out_ready  in  1  execute stage accepts slot
- out_instr, out_pc  out  word_t  registered instruction and PC
- out_rdat1, out_rdat2  out  word_t  registered operands
- out_dest  out  regbits_t  destination register
- out_wen  out  1  instruction writes a register

## Operation
- rf_rsel1 = in_instr[25:21], rf_rsel2 = in_instr[20:16], always combinational. There is no gating on in_valid.
- Destination decode:
  - opcode 0: rd, with wen = 1, except funct 0x08 (JR), which has no write.
  - JAL: register 31.
  - I-type ALU and loads: rt.
  - Stores, branches and J: no write.
  - A destination of $0 forces wen = 0.
- Operand: if source is $0, the operand is 0. Otherwise, if WB_BYPASS && wb_wen && wb_wsel == source, the operand is wb_wdat. Otherwise it is rf_rdat.
- Scoreboard: a 32-bit busy vector. Bit 0 is never set.
  - Set busy[dest] on issue when wen = 1.
  - Clear busy[wb_wsel] when wb_wen = 1.
  - If set and clear hit the same bit in the same cycle, set wins.
- Hazard is asserted when any of rs, rt or dest (nonzero) is busy and not being cleared this cycle.
  - Checking all three conservatively stalls on unused fields.
  - The dest check prevents WAW.
  - With WB_BYPASS = 0, a bit being cleared this cycle still counts as a hazard.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Issue (in_valid && in_ready): load all out_* fields and set out_valid = 1.
- When out_valid && out_ready and there is no issue, out_valid goes to 0.
- When out_valid && !out_ready, all out_* fields hold.
- Flush: out_valid goes to 0, and no issue happens that cycle. If the killed slot had out_wen, clear busy[out_dest]. Downstream instructions' busy bits are untouched.
- Reset: busy = 0, out_valid = 0, and all out_* data fields = 0.

## Timing
- Latency: 1 cycle from issue to out_valid.
- Throughput: 1 instruction/cycle with no hazards.
- in_ready depends combinationally on in_instr, out_ready, flush and wb_*. There is no combinational path from in_valid to in_ready.
- Hazard release: an instruction stalled on register r issues in the same cycle that wb_wen writes r (WB_BYPASS = 1), or one cycle later (WB_BYPASS = 0).
- RST has priority over flush, issue and handshake. Reset mid-stall drops the held instruction.
- Simultaneous flush and wb clear of the same bit: the bit ends up 0.

## Structure
- cpu_types_pkg holds word_t, regbits_t, the opcode_t enum (RTYPE, J, JAL, BEQ, BNE, LW, SW, ADDI…), the funct constant JR, and the constant REG_RA = 31.
- Sub-module reg_scoreboard contains:
  - the busy vector;
  - the set and clear ports;
  - three query ports returning busy-and-not-cleared.
- The operand_fetch top level holds the decode, the bypass muxes and the output register.

## Test plan
- Back-to-back independent ADDs:
  - Stimulus: in_valid continuous, out_ready = 1.
  - Response: one issue per cycle; out_rdat taken from rf_rdat.
- RAW stall:
  - Stimulus: issue LW $5, then ADD $6,$5,$5.
  - Response: in_ready = 0 until wb_wen with wsel 5 and wdat 0x1234.
  - With WB_BYPASS = 1, issue happens in that same cycle with out_rdat1 = out_rdat2 = 0x1234.
  - With WB_BYPASS = 0, issue happens one cycle later.
- $0 handling:
  - Stimulus: ADD $0,$0,$0, with rf_rdat = 0xFFFFFFFF.
  - Response: out_rdat = 0, out_wen = 0, busy stays 0, and the next instruction is not stalled.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles with the slot full.
  - Response: out_* hold and in_ready = 0. Once out_ready = 1, the slot drains and the next instruction issues that cycle.
- Flush:
  - Stimulus: issue ADDI $7; flush next cycle.
  - Response: out_valid = 0 and busy[7] = 0. A following ADD using $7 issues without waiting for write-back.
- Reset mid-stall:
  - Stimulus: assert RST while stalled on $5.
  - Response: out_valid = 0 and busy all 0. The first instruction after reset issues immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared MIPS types for the decode side: word/register types, opcodes,
// the output-slot bundle and the destination-register decode helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        BLEZ  = 6'h06,
        BGTZ  = 6'h07,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LB    = 6'h20,
        LH    = 6'h21,
        LW    = 6'h23,
        LBU   = 6'h24,
        LHU   = 6'h25,
        SB    = 6'h28,
        SH    = 6'h29,
        SW    = 6'h2B
    } opcode_t;

    localparam logic [5:0] FUNCT_JR = 6'h08;
    localparam regbits_t   REG_RA   = 5'd31;
    localparam regbits_t   REG_ZERO = 5'd0;

    typedef struct packed {
        regbits_t dest;
        logic     wen;
    } dest_t;

    typedef struct packed {
        logic     valid;
        word_t    instr;
        word_t    pc;
        word_t    rdat1;
        word_t    rdat2;
        regbits_t dest;
        logic     wen;
    } slot_t;

    // Non-writing instructions report dest 0 so the scoreboard
    // never sees a stray destination for stores/branches/jumps.
    function automatic dest_t decode_dest(
        input logic [5:0] op,
        input regbits_t   rt,
        input regbits_t   rd,
        input logic [5:0] funct
    );
        dest_t d;
        d.dest = REG_ZERO;
        d.wen  = 1'b0;
        unique case (op)
            RTYPE: begin
                if (funct != FUNCT_JR) begin
                    d.dest = rd;
                    d.wen  = 1'b1;
                end
            end
            JAL: begin
                d.dest = REG_RA;
                d.wen  = 1'b1;
            end
            ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
            LB, LH, LW, LBU, LHU: begin
                d.dest = rt;
                d.wen  = 1'b1;
            end
            default: begin
                d.dest = REG_ZERO;
                d.wen  = 1'b0;
            end
        endcase
        if (d.dest == REG_ZERO) d.wen = 1'b0;
        if (!d.wen) d.dest = REG_ZERO;
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the fetch-side, register-file, write-back snoop and execute-side
// signals of the operand fetch stage. slave = stage view, master = environment.
interface operand_fetch_if;
    import cpu_types_pkg::*;

    logic     in_valid;
    logic     in_ready;
    word_t    in_instr;
    word_t    in_pc;
    logic     flush;
    regbits_t rf_rsel1;
    regbits_t rf_rsel2;
    word_t    rf_rdat1;
    word_t    rf_rdat2;
    logic     wb_wen;
    regbits_t wb_wsel;
    word_t    wb_wdat;
    logic     out_valid;
    logic     out_ready;
    word_t    out_instr;
    word_t    out_pc;
    word_t    out_rdat1;
    word_t    out_rdat2;
    regbits_t out_dest;
    logic     out_wen;

    modport slave (
        input  in_valid, in_instr, in_pc, flush,
        input  rf_rdat1, rf_rdat2,
        input  wb_wen, wb_wsel, wb_wdat,
        input  out_ready,
        output in_ready, rf_rsel1, rf_rsel2,
        output out_valid, out_instr, out_pc,
        output out_rdat1, out_rdat2, out_dest, out_wen
    );

    modport master (
        output in_valid, in_instr, in_pc, flush,
        output rf_rdat1, rf_rdat2,
        output wb_wen, wb_wsel, wb_wdat,
        output out_ready,
        input  in_ready, rf_rsel1, rf_rsel2,
        input  out_valid, out_instr, out_pc,
        input  out_rdat1, out_rdat2, out_dest, out_wen
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Register busy vector: set on issue, cleared by write-back or slot kill.
// Ports: clk_i/rst_i, set_*, wb_clr_*, kill_clr_*, qry_sel_i -> qry_busy_o.
module reg_scoreboard
    import cpu_types_pkg::*;
#(
    parameter bit CLR_RELEASES = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           set_en_i,
    input  regbits_t       set_sel_i,
    input  logic           wb_clr_en_i,
    input  regbits_t       wb_clr_sel_i,
    input  logic           kill_clr_en_i,
    input  regbits_t       kill_clr_sel_i,
    input  regbits_t [2:0] qry_sel_i,
    output logic     [2:0] qry_busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] wb_mask;
    logic [31:0] kill_mask;
    logic [31:0] set_mask;

    // Set is applied after both clears so it wins on a collision.
    always_comb begin
        wb_mask   = '0;
        kill_mask = '0;
        set_mask  = '0;
        if (wb_clr_en_i)   wb_mask[wb_clr_sel_i]     = 1'b1;
        if (kill_clr_en_i) kill_mask[kill_clr_sel_i] = 1'b1;
        if (set_en_i)      set_mask[set_sel_i]       = 1'b1;
        busy_d    = (busy_q & ~wb_mask & ~kill_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Without bypass a write-back in flight still blocks its register.
    always_comb begin
        qry_busy_o = '0;
        for (int i = 0; i < 3; i++) begin
            qry_busy_o[i] = busy_q[qry_sel_i[i]]
                && !(CLR_RELEASES && wb_mask[qry_sel_i[i]]);
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read selects, write-back bypass, scoreboard stall,
// output slot. Ports: CLK, RST (sync, high), bus (operand_fetch_if.slave).
module operand_fetch
    import cpu_types_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    operand_fetch_if.slave bus
);

    regbits_t rs;
    regbits_t rt;
    dest_t    dec;
    logic [2:0] qbusy;
    logic     hazard;
    logic     ready;
    logic     issue;
    logic     kill_clr;
    word_t    op1;
    word_t    op2;
    slot_t    slot_q;
    slot_t    slot_d;

    assign rs = bus.in_instr[25:21];
    assign rt = bus.in_instr[20:16];
    assign bus.rf_rsel1 = rs;
    assign bus.rf_rsel2 = rt;

    assign dec = decode_dest(bus.in_instr[31:26], rt,
                             bus.in_instr[15:11], bus.in_instr[5:0]);

    always_comb begin
        op1 = bus.rf_rdat1;
        op2 = bus.rf_rdat2;
        if (WB_BYPASS && bus.wb_wen && bus.wb_wsel == rs) op1 = bus.wb_wdat;
        if (WB_BYPASS && bus.wb_wen && bus.wb_wsel == rt) op2 = bus.wb_wdat;
        if (rs == REG_ZERO) op1 = '0;
        if (rt == REG_ZERO) op2 = '0;
    end

    assign hazard = |qbusy;
    assign ready  = (!slot_q.valid || bus.out_ready) && !hazard && !bus.flush;
    assign issue  = bus.in_valid && ready;
    assign kill_clr = bus.flush && slot_q.valid && slot_q.wen;
    assign bus.in_ready = ready;

    reg_scoreboard #(
        .CLR_RELEASES (WB_BYPASS)
    ) u_sb (
        .clk_i          (CLK),
        .rst_i          (RST),
        .set_en_i       (issue && dec.wen),
        .set_sel_i      (dec.dest),
        .wb_clr_en_i    (bus.wb_wen),
        .wb_clr_sel_i   (bus.wb_wsel),
        .kill_clr_en_i  (kill_clr),
        .kill_clr_sel_i (slot_q.dest),
        .qry_sel_i      ({dec.dest, rt, rs}),
        .qry_busy_o     (qbusy)
    );

    always_comb begin
        slot_d = slot_q;
        if (bus.flush) begin
            slot_d.valid = 1'b0;
        end else if (issue) begin
            slot_d.valid = 1'b1;
            slot_d.instr = bus.in_instr;
            slot_d.pc    = bus.in_pc;
            slot_d.rdat1 = op1;
            slot_d.rdat2 = op2;
            slot_d.dest  = dec.dest;
            slot_d.wen   = dec.wen;
        end else if (bus.out_ready) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign bus.out_valid = slot_q.valid;
    assign bus.out_instr = slot_q.instr;
    assign bus.out_pc    = slot_q.pc;
    assign bus.out_rdat1 = slot_q.rdat1;
    assign bus.out_rdat2 = slot_q.rdat2;
    assign bus.out_dest  = slot_q.dest;
    assign bus.out_wen   = slot_q.wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: two instances (bypass off/on) share stimulus and
// are checked each cycle against a per-instance behavioural model.
module tb_operand_fetch;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst;
    logic     in_valid, flush, out_ready, wb_wen;
    word_t    in_instr, in_pc, rdat1, rdat2, wb_wdat;
    regbits_t wb_wsel;
    int       vectors = 0;
    int       miscompares = 0;
    logic     armed = 1'b0;

    typedef struct {
        logic     v;
        word_t    instr;
        word_t    pc;
        word_t    r1;
        word_t    r2;
        regbits_t dest;
        logic     wen;
    } mslot_t;

    logic [31:0] m_busy [2];
    mslot_t      m_slot [2];

    operand_fetch_if ifc0 ();
    operand_fetch_if ifc1 ();

    assign ifc0.in_valid = in_valid;  assign ifc1.in_valid = in_valid;
    assign ifc0.in_instr = in_instr;  assign ifc1.in_instr = in_instr;
    assign ifc0.in_pc = in_pc;        assign ifc1.in_pc = in_pc;
    assign ifc0.flush = flush;        assign ifc1.flush = flush;
    assign ifc0.rf_rdat1 = rdat1;     assign ifc1.rf_rdat1 = rdat1;
    assign ifc0.rf_rdat2 = rdat2;     assign ifc1.rf_rdat2 = rdat2;
    assign ifc0.wb_wen = wb_wen;      assign ifc1.wb_wen = wb_wen;
    assign ifc0.wb_wsel = wb_wsel;    assign ifc1.wb_wsel = wb_wsel;
    assign ifc0.wb_wdat = wb_wdat;    assign ifc1.wb_wdat = wb_wdat;
    assign ifc0.out_ready = out_ready; assign ifc1.out_ready = out_ready;

    operand_fetch #(.WB_BYPASS(1'b0)) u_dut0 (
        .CLK (clk), .RST (rst), .bus (ifc0)
    );
    operand_fetch #(.WB_BYPASS(1'b1)) u_dut1 (
        .CLK (clk), .RST (rst), .bus (ifc1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Destination per the ISA rules; no-write means dest 0.
    function automatic void m_dec(input word_t ins, output regbits_t d,
                                  output logic w);
        int op;
        op = int'(ins[31:26]);
        d = 5'd0;
        w = 1'b0;
        if (op == 0) begin
            d = ins[15:11];
            w = (ins[5:0] != 6'h08);
        end else if (op == 3) begin
            d = 5'd31;
            w = 1'b1;
        end else if ((op >= 8 && op <= 15) || op == 32 || op == 33 ||
                     op == 35 || op == 36 || op == 37) begin
            d = ins[20:16];
            w = 1'b1;
        end
        if (d == 5'd0) w = 1'b0;
        if (!w) d = 5'd0;
    endfunction

    function automatic logic m_blocks(input int k, input regbits_t r);
        if (r == 5'd0 || !m_busy[k][r]) return 1'b0;
        if (k == 1 && wb_wen && wb_wsel == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_ready(input int k);
        regbits_t d;
        logic     w;
        logic     haz;
        m_dec(in_instr, d, w);
        haz = m_blocks(k, in_instr[25:21]) || m_blocks(k, in_instr[20:16])
              || m_blocks(k, d);
        return (!m_slot[k].v || out_ready) && !haz && !flush;
    endfunction

    function automatic word_t m_opnd(input int k, input regbits_t s,
                                     input word_t rf);
        if (s == 5'd0) return 32'd0;
        if (k == 1 && wb_wen && wb_wsel == s) return wb_wdat;
        return rf;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            regbits_t    d;
            logic        w;
            logic        iss;
            logic [31:0] nb;
            mslot_t      ns;
            if (rst) begin
                ns.v = 1'b0; ns.instr = '0; ns.pc = '0; ns.r1 = '0;
                ns.r2 = '0; ns.dest = '0; ns.wen = 1'b0;
                m_busy[k] <= '0;
                m_slot[k] <= ns;
            end else begin
                m_dec(in_instr, d, w);
                iss = in_valid && m_ready(k);
                nb = m_busy[k];
                if (wb_wen) nb[wb_wsel] = 1'b0;
                if (flush && m_slot[k].v && m_slot[k].wen)
                    nb[m_slot[k].dest] = 1'b0;
                if (iss && w) nb[d] = 1'b1;
                nb[0] = 1'b0;
                ns = m_slot[k];
                if (flush) begin
                    ns.v = 1'b0;
                end else if (iss) begin
                    ns.v = 1'b1;
                    ns.instr = in_instr;
                    ns.pc = in_pc;
                    ns.r1 = m_opnd(k, in_instr[25:21], rdat1);
                    ns.r2 = m_opnd(k, in_instr[20:16], rdat2);
                    ns.dest = d;
                    ns.wen = w;
                end else if (out_ready) begin
                    ns.v = 1'b0;
                end
                m_busy[k] <= nb;
                m_slot[k] <= ns;
            end
        end
    end

    task automatic cmp_dut(input int k, input logic ov, input logic ir,
                           input regbits_t s1, input regbits_t s2,
                           input word_t oi, input word_t opc,
                           input word_t r1, input word_t r2,
                           input regbits_t od, input logic ow);
        string p;
        p = $sformatf("d%0d", k);
        chk({p, ".out_valid"}, ov, m_slot[k].v);
        chk({p, ".in_ready"}, ir, m_ready(k));
        chk({p, ".rf_rsel1"}, s1, in_instr[25:21]);
        chk({p, ".rf_rsel2"}, s2, in_instr[20:16]);
        if (m_slot[k].v) begin
            chk({p, ".out_instr"}, oi, m_slot[k].instr);
            chk({p, ".out_pc"}, opc, m_slot[k].pc);
            chk({p, ".out_rdat1"}, r1, m_slot[k].r1);
            chk({p, ".out_rdat2"}, r2, m_slot[k].r2);
            chk({p, ".out_dest"}, od, m_slot[k].dest);
            chk({p, ".out_wen"}, ow, m_slot[k].wen);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_dut(0, ifc0.out_valid, ifc0.in_ready, ifc0.rf_rsel1,
                    ifc0.rf_rsel2, ifc0.out_instr, ifc0.out_pc,
                    ifc0.out_rdat1, ifc0.out_rdat2, ifc0.out_dest,
                    ifc0.out_wen);
            cmp_dut(1, ifc1.out_valid, ifc1.in_ready, ifc1.rf_rsel1,
                    ifc1.rf_rsel2, ifc1.out_instr, ifc1.out_pc,
                    ifc1.out_rdat1, ifc1.out_rdat2, ifc1.out_dest,
                    ifc1.out_wen);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input word_t ins, input logic ordy,
                       input logic fl, input logic we, input regbits_t ws,
                       input word_t wd);
        in_valid = v;
        in_instr = ins;
        in_pc = in_pc + 32'd4;
        out_ready = ordy;
        flush = fl;
        wb_wen = we;
        wb_wsel = ws;
        wb_wdat = wd;
    endtask

    function automatic word_t rnd_instr();
        logic [5:0] op;
        logic [5:0] fn;
        regbits_t   a, b, c;
        case ($urandom_range(0, 10))
            0, 1, 2: op = 6'h00;
            3:       op = 6'h03;
            4:       op = 6'h08;
            5:       op = 6'h0D;
            6:       op = 6'h23;
            7:       op = 6'h2B;
            8:       op = 6'h04;
            9:       op = 6'h02;
            default: op = 6'h0F;
        endcase
        case ($urandom_range(0, 3))
            0:       fn = 6'h20;
            1:       fn = 6'h21;
            2:       fn = 6'h08;
            default: fn = 6'h2A;
        endcase
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        return {op, a, b, c, 5'($urandom_range(0, 31)), fn};
    endfunction

    initial begin
        rst = 1'b1;
        in_pc = 32'h0000_1000;
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        rdat1 = '0;
        rdat2 = '0;
        step();
        step();
        rst = 1'b0;
        armed = 1'b1;
        #3;
        chk("rst.valid0", ifc0.out_valid, 1'b0);
        chk("rst.valid1", ifc1.out_valid, 1'b0);
        chk("rst.instr", ifc1.out_instr, 32'd0);
        chk("rst.pc", ifc0.out_pc, 32'd0);
        chk("rst.rdat1", ifc1.out_rdat1, 32'd0);
        chk("rst.dest", ifc0.out_dest, 5'd0);

        // ADD $0,$0,$0 with all-ones RF data
        step();
        rdat1 = 32'hFFFF_FFFF;
        rdat2 = 32'hFFFF_FFFF;
        drv(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("zero.ready", ifc1.in_ready, 1'b1);
        step();
        drv(1'b1, 32'h2001_0005, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("zero.valid", ifc1.out_valid, 1'b1);
        chk("zero.rdat1", ifc1.out_rdat1, 32'd0);
        chk("zero.rdat2", ifc0.out_rdat2, 32'd0);
        chk("zero.wen", ifc1.out_wen, 1'b0);
        chk("zero.next_ready", ifc0.in_ready, 1'b1);

        // LW $5 then ADD $6,$5,$5
        step();
        rdat1 = '0;
        rdat2 = '0;
        drv(1'b1, 32'h8C05_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        rdat1 = 32'hDEAD_0000;
        rdat2 = 32'hDEAD_0000;
        drv(1'b1, 32'h00A5_3020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("raw.stall0", ifc0.in_ready, 1'b0);
        chk("raw.stall1", ifc1.in_ready, 1'b0);
        step();
        step();
        drv(1'b1, 32'h00A5_3020, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        #3;
        chk("raw.byp_ready", ifc1.in_ready, 1'b1);
        chk("raw.nobyp_ready", ifc0.in_ready, 1'b0);
        step();
        rdat1 = 32'h0000_1234;
        rdat2 = 32'h0000_1234;
        drv(1'b1, 32'h00A5_3020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("raw.byp_rdat1", ifc1.out_rdat1, 32'h0000_1234);
        chk("raw.byp_rdat2", ifc1.out_rdat2, 32'h0000_1234);
        chk("raw.nobyp_late", ifc0.in_ready, 1'b1);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd0);
        #3;
        chk("raw.nobyp_rdat1", ifc0.out_rdat1, 32'h0000_1234);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'd0);
        step();

        // backpressure
        drv(1'b1, 32'h2002_0007, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h2003_0009, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            #3;
            chk("bp.hold_instr", ifc0.out_instr, 32'h2002_0007);
            chk("bp.hold_valid", ifc1.out_valid, 1'b1);
            chk("bp.ready", ifc1.in_ready, 1'b0);
            step();
        end
        drv(1'b1, 32'h2003_0009, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("bp.release", ifc0.in_ready, 1'b1);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd0);
        #3;
        chk("bp.next_instr", ifc1.out_instr, 32'h2003_0009);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'd0);
        step();

        // flush of ADDI $7
        drv(1'b1, 32'h2007_0001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        #3;
        chk("fl.ready", ifc1.in_ready, 1'b0);
        step();
        drv(1'b1, 32'h00E7_4020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("fl.valid", ifc1.out_valid, 1'b0);
        chk("fl.no_wait0", ifc0.in_ready, 1'b1);
        chk("fl.no_wait1", ifc1.in_ready, 1'b1);
        step();
        drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8, 32'd0);
        #3;
        chk("fl.issued", ifc0.out_valid, 1'b1);
        step();

        // reset while stalled on $5
        drv(1'b1, 32'h8C05_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drv(1'b1, 32'h00A5_3020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("rs.stall", ifc1.in_ready, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #3;
        chk("rs.valid", ifc1.out_valid, 1'b0);
        chk("rs.ready0", ifc0.in_ready, 1'b1);
        chk("rs.ready1", ifc1.in_ready, 1'b1);
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 9) < 8);
            in_instr = rnd_instr();
            in_pc = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            wb_wen = ($urandom_range(0, 9) < 3);
            wb_wsel = ($urandom_range(0, 8) == 8) ? 5'd31
                      : 5'($urandom_range(0, 7));
            wb_wdat = $urandom;
            rdat1 = $urandom;
            rdat2 = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
